seg7_scan_mux: RTL and testbench
================================

Name: seg7_scan_mux

Overview:
Multi-digit scanned 7-segment display driver. It sits directly downstream of the digit counter/decoder stage. Producers hand it a packed vector of hex/BCD digits plus decimal points through a valid/ready handshake. It time-multiplexes those digits onto one shared 7-segment bus with one-hot digit enables, and applies inter-digit blanking and optional leading-zero suppression. New values take effect only at frame boundaries, so no tearing is visible.

Parameters:
NUM_DIGITS, 4, number of scanned digits (2..8)
SCAN_COUNT, 24'd10_000, clock cycles per digit slot (>= 2)
BLANK_COUNT, 16, cycles at the start of each slot with all outputs dark (< SCAN_COUNT)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
load_valid  input  1  producer offers new display contents
load_ready  output  1  block can accept a load this cycle
load_digits  input  4*NUM_DIGITS  digit i in bits [4i+3:4i]; digit 0 = rightmost
load_dp  input  NUM_DIGITS  decimal point per digit
lz_suppress  input  1  leading-zero suppression enable, sampled live
segments  output  7  segment drive; bit0=a .. bit6=g, active high
dp  output  1  decimal point of the currently enabled digit
digit_en  output  NUM_DIGITS  one-hot active-high digit select; all zero while blanking
frame_done  output  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Reset (async, immediate, no clock needed): segments=0, dp=0, digit_en=0, frame_done=0, load_ready=1. Display register and pending register are cleared, pending flag is cleared, idx=0, slot_cnt=0.
- Scan counters: slot_cnt counts 0..SCAN_COUNT-1 and then wraps. On wrap, idx advances 0..NUM_DIGITS-1 and then wraps to 0. A frame is NUM_DIGITS*SCAN_COUNT cycles.
- Two-state FSM per slot:
  - BLANK while slot_cnt < BLANK_COUNT: digit_en=0, segments=0, dp=0.
  - SHOW otherwise: digit_en = 1<<idx; segments = decode(digit[idx]); dp = disp_dp[idx].
- Output timing: segments, dp and digit_en are registered and reflect the (idx, slot_cnt) of the previous cycle. That is one cycle of latency.
- Decode table: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- Leading-zero suppression: when lz_suppress=1, digit i>0 forces segments=0 if every digit j>=i of the display register is 0. digit_en and dp are unaffected. Digit 0 is never suppressed.
- Handshake:
  - A load is accepted on a cycle with load_valid && load_ready.
  - The accepted data goes into the pending register and sets the pending flag.
  - load_ready = !pending.
- Frame boundary: frame_done is asserted when idx==NUM_DIGITS-1 && slot_cnt==SCAN_COUNT-1. On that cycle's edge:
  - If pending is set, pending moves to the display register and the pending flag is cleared.
  - load_ready is low during that cycle and returns high the next cycle.
- Multiple loads between frame boundaries: only one is held. Further loads stall until the next frame boundary.
- load_valid may drop without acceptance; there is no stickiness requirement on the producer.
- Reset mid-frame: the scan restarts at idx 0 in BLANK, and any pending data is discarded.
- All counters use modular wrap. No other state exists.

Decomposition:
- Shared package: the 16-entry segment encoding constants and the segment bit-order definition (a..g = bit0..bit6), shared with the existing decoder stage.
- One sub-module, seg7_hex_decode: purely combinational 4-bit to 7-bit lookup, instantiated once on the selected digit.
- Scan FSM, handshake and registers stay in seg7_scan_mux.

Test Plan:
(Bench uses NUM_DIGITS=4, SCAN_COUNT=8, BLANK_COUNT=2, so a frame is 32 cycles.)
1. Assert reset mid-run with no clock edge → segments, digit_en, dp and frame_done are 0 immediately; load_ready=1; after release, frame_done first pulses 32 cycles later.
2. Load 16'h1234, dp=4'b0000, lz=0 → after the next frame_done: digit_en=0001 shows 1100110, 0010 shows 1001111, 0100 shows 1011011, 1000 shows 0000110. Each enable is high 6 cycles after 2 dark cycles.
3. Load 16'h0050, lz=1 → digits 3 and 2 have segments 0000000 while enabled; digit 1 shows 1101101; digit 0 shows 0111111. Load 16'h0000 with lz=1 → only digit 0 lights, showing 0111111.
4. Hold load_valid across a frame: first load accepted, load_ready=0 until the cycle after frame_done. The second load is accepted then and is displayed only after the following frame_done.
5. Load 16'hAF00, dp=4'b0100 → digit 3 shows 1110111, digit 2 shows 1110001 with dp=1, and the other digits have dp=0.

Source files
------------

// File: rtl/seg7_scan_mux_pkg.sv
// Shared 7-segment definitions: segment bit order (a = bit0 .. g = bit6),
// the hex glyph table and the per-slot scan phase encoding.
package seg7_scan_mux_pkg;

   // Packed so that field a lands on bit 0 and g on bit 6.
   typedef struct packed {
      logic g;
      logic f;
      logic e;
      logic d;
      logic c;
      logic b;
      logic a;
   } seg_t;

   typedef enum logic {
      ST_BLANK,
      ST_SHOW
   } scan_state_t;

   // Glyphs written g..a, active high.
   localparam seg_t SEG_LUT [16] = '{
      7'b0111111,  // 0
      7'b0000110,  // 1
      7'b1011011,  // 2
      7'b1001111,  // 3
      7'b1100110,  // 4
      7'b1101101,  // 5
      7'b1111101,  // 6
      7'b0000111,  // 7
      7'b1111111,  // 8
      7'b1101111,  // 9
      7'b1110111,  // A
      7'b1111100,  // b
      7'b0111001,  // C
      7'b1011110,  // d
      7'b1111001,  // E
      7'b1110001   // F
   };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to 7-segment glyph lookup.
// Ports: hex (4-bit digit in), seg (a..g = bit0..bit6, active high).
module seg7_hex_decode
   import seg7_scan_mux_pkg::*;
(
   input  logic [3:0] hex,
   output seg_t       seg
);

   assign seg = SEG_LUT[hex];

endmodule

// File: rtl/seg7_scan_mux.sv
// Scanned multi-digit 7-segment driver with frame-synchronous loading.
// Ports: clk, reset (async high); load_valid/load_ready handshake with
// load_digits/load_dp; lz_suppress (live); segments, dp, digit_en
// (registered, one cycle latency); frame_done (last cycle of frame).
module seg7_scan_mux
   import seg7_scan_mux_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned SCAN_COUNT  = 24'd10_000,
   parameter int unsigned BLANK_COUNT = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_digits,
   input  logic [NUM_DIGITS-1:0]   load_dp,
   input  logic                    lz_suppress,
   output logic [6:0]              segments,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    frame_done
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int CNT_W = $clog2(SCAN_COUNT);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SCAN_COUNT - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_COUNT);

   // Slot 0 is dark unless blanking is disabled entirely.
   localparam scan_state_t ST_RESET =
      (BLANK_COUNT > 0) ? ST_BLANK : ST_SHOW;

   scan_state_t state_q, state_d;

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] slot_q, slot_d;

   logic [4*NUM_DIGITS-1:0] disp_digits;
   logic [NUM_DIGITS-1:0]   disp_dp;
   logic [4*NUM_DIGITS-1:0] pend_digits;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic                    pending;

   logic                  slot_wrap;
   logic                  idx_wrap;
   logic                  load_fire;
   logic                  suppress;
   logic [3:0]            sel_digit;
   seg_t                  dec_seg;
   logic [NUM_DIGITS-1:0] zero_from;

   logic [6:0]            seg_d;
   logic                  dp_d;
   logic [NUM_DIGITS-1:0] en_d;

   assign slot_wrap  = (slot_q == LAST_SLOT);
   assign idx_wrap   = (idx_q == LAST_IDX);
   assign frame_done = slot_wrap & idx_wrap;

   // Held low on the boundary cycle so a new load never races
   // the pending-to-display transfer.
   assign load_ready = ~pending & ~frame_done;
   assign load_fire  = load_valid & load_ready;

   assign sel_digit = disp_digits[4*idx_q +: 4];

   seg7_hex_decode u_dec (
      .hex (sel_digit),
      .seg (dec_seg)
   );

   // zero_from[i]: digit i and everything left of it is zero.
   always_comb begin
      logic run;
      run       = 1'b1;
      zero_from = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run          = run & (disp_digits[4*i +: 4] == 4'd0);
         zero_from[i] = run;
      end
   end

   assign suppress = lz_suppress
                   & (idx_q != '0)
                   & zero_from[idx_q];

   always_comb begin
      slot_d = slot_q + 1'b1;
      idx_d  = idx_q;
      seg_d  = '0;
      dp_d   = 1'b0;
      en_d   = '0;

      if (slot_wrap) begin
         slot_d = '0;
         idx_d  = idx_wrap ? '0 : idx_q + 1'b1;
      end

      state_d = (slot_d < BLANK_END) ? ST_BLANK : ST_SHOW;

      unique case (state_q)
         ST_BLANK: begin
         end
         ST_SHOW: begin
            en_d[idx_q] = 1'b1;
            seg_d       = suppress ? 7'd0 : dec_seg;
            dp_d        = disp_dp[idx_q];
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_RESET;
         idx_q    <= '0;
         slot_q   <= '0;
         segments <= '0;
         dp       <= 1'b0;
         digit_en <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         slot_q   <= slot_d;
         segments <= seg_d;
         dp       <= dp_d;
         digit_en <= en_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_digits <= '0;
         disp_dp     <= '0;
         pend_digits <= '0;
         pend_dp     <= '0;
         pending     <= 1'b0;
      end else if (frame_done && pending) begin
         disp_digits <= pend_digits;
         disp_dp     <= pend_dp;
         pending     <= 1'b0;
      end else if (load_fire) begin
         pend_digits <= load_digits;
         pend_dp     <= load_dp;
         pending     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: random and directed loads against a
// frame-level reference model; N=4, SCAN=8, BLANK=2 (32-cycle frame).
module tb_seg7_scan_mux;

   localparam int N     = 4;
   localparam int SCAN  = 8;
   localparam int BLANK = 2;
   localparam int FRAME = N * SCAN;

   localparam logic [6:0] HEX7 [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          load_valid = 1'b0;
   logic          load_ready;
   logic [15:0]   load_digits = '0;
   logic [3:0]    load_dp = '0;
   logic          lz_suppress = 1'b0;
   logic [6:0]    segments;
   logic          dp;
   logic [3:0]    digit_en;
   logic          frame_done;

   always #5 clk = ~clk;

   seg7_scan_mux #(
      .NUM_DIGITS  (N),
      .SCAN_COUNT  (SCAN),
      .BLANK_COUNT (BLANK)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_digits (load_digits),
      .load_dp     (load_dp),
      .lz_suppress (lz_suppress),
      .segments    (segments),
      .dp          (dp),
      .digit_en    (digit_en),
      .frame_done  (frame_done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model state: c = clock edges since reset release.
   int          c;
   logic [15:0] m_disp, m_pd;
   logic [3:0]  m_ddp, m_pdp;
   bit          m_pend;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [3:0]  e_en;
   int          first_fd;
   int          acc_seen;

   int          cap_on  [N];
   logic [6:0]  cap_seg [N];
   logic        cap_dp  [N];

   task automatic model_reset();
      c = 0;
      m_disp = '0; m_pd = '0;
      m_ddp = '0; m_pdp = '0;
      m_pend = 1'b0;
      e_seg = '0; e_dp = 1'b0; e_en = '0;
      first_fd = -1;
   endtask

   function automatic bit m_ready();
      return !m_pend && (c % FRAME != FRAME - 1);
   endfunction

   // Entered at a falling edge; drives inputs, advances the model
   // over the next rising edge and checks at the following fall.
   task automatic cycle(input logic v, input logic [15:0] d,
                        input logic [3:0] p, input logic lz);
      int slot, idx;
      bit fd, rdy;
      logic [3:0] dig;
      load_valid = v; load_digits = d;
      load_dp = p; lz_suppress = lz;
      if (v && load_ready) acc_seen++;
      slot = c % SCAN;
      idx  = (c / SCAN) % N;
      e_seg = '0; e_dp = 1'b0; e_en = '0;
      if (slot >= BLANK) begin
         e_en = 4'(1 << idx);
         e_dp = m_ddp[idx];
         dig  = 4'(m_disp >> (4 * idx));
         if (lz && idx > 0 && (m_disp >> (4 * idx)) == 0)
            e_seg = '0;
         else
            e_seg = HEX7[dig];
      end
      fd  = (c % FRAME == FRAME - 1);
      rdy = !m_pend && !fd;
      if (fd && m_pend) begin
         m_disp = m_pd; m_ddp = m_pdp; m_pend = 1'b0;
      end else if (v && rdy) begin
         m_pd = d; m_pdp = p; m_pend = 1'b1;
      end
      c++;
      @(negedge clk);
      check("segments", 32'(segments), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
      check("digit_en", 32'(digit_en), 32'(e_en));
      check("frame_done", 32'(frame_done),
            32'(c % FRAME == FRAME - 1));
      check("load_ready", 32'(load_ready), 32'(m_ready()));
      if (frame_done && first_fd < 0) first_fd = c;
      for (int k = 0; k < N; k++) begin
         if (digit_en == 4'(1 << k)) begin
            cap_on[k]++;
            cap_seg[k] = segments;
            cap_dp[k]  = dp;
         end
      end
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                          input logic lz);
      int k = 0;
      while (!m_ready() && k < 80) begin
         cycle(1'b0, '0, '0, lz);
         k++;
      end
      check("load_wait", 32'(k < 80), 32'd1);
      cycle(1'b1, d, p, lz);
   endtask

   task automatic to_frame_start(input logic lz);
      int k = 0;
      while (c % FRAME != 0 && k < 2 * FRAME) begin
         cycle(1'b0, '0, '0, lz);
         k++;
      end
      check("frame_align", 32'(c % FRAME), 32'd0);
   endtask

   task automatic frame_capture(input logic v, input logic [15:0] d,
                                input logic lz);
      for (int k = 0; k < N; k++) begin
         cap_on[k] = 0; cap_seg[k] = 'x; cap_dp[k] = 1'bx;
      end
      repeat (FRAME) cycle(v, d, '0, lz);
   endtask

   task automatic check_frame(input string tag,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input logic [3:0] dps);
      logic [6:0] exp_s [N];
      exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2; exp_s[3] = s3;
      for (int k = 0; k < N; k++) begin
         check($sformatf("%s_seg%0d", tag, k),
               32'(cap_seg[k]), 32'(exp_s[k]));
         check($sformatf("%s_dp%0d", tag, k),
               32'(cap_dp[k]), 32'(dps[k]));
         check($sformatf("%s_on%0d", tag, k),
               32'(cap_on[k]), SCAN - BLANK);
      end
   endtask

   task automatic reset_pulse();
      #2 reset = 1'b1;
      #1;
      check("rst_segments", 32'(segments), 32'd0);
      check("rst_digit_en", 32'(digit_en), 32'd0);
      check("rst_dp", 32'(dp), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_load_ready", 32'(load_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] rd;
      logic        lz;
      int          nz;
      acc_seen = 0;
      model_reset();
      #12;
      check("init_segments", 32'(segments), 32'd0);
      check("init_digit_en", 32'(digit_en), 32'd0);
      check("init_load_ready", 32'(load_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      model_reset();

      // Idle run, then an asynchronous reset mid-frame.
      repeat (45) cycle(1'b0, '0, '0, 1'b0);
      do_load(16'h4321, 4'b1010, 1'b0);
      repeat (37) cycle(1'b0, '0, '0, 1'b0);
      do_load(16'h8888, 4'b0001, 1'b0);
      reset_pulse();
      repeat (40) cycle(1'b0, '0, '0, 1'b0);
      check("first_frame_done", first_fd, FRAME - 1);

      do_load(16'h1234, 4'b0000, 1'b0);
      to_frame_start(1'b0);
      frame_capture(1'b0, '0, 1'b0);
      check_frame("h1234", 7'b0000110, 7'b1011011,
                  7'b1001111, 7'b1100110, 4'b0000);

      do_load(16'h0050, 4'b0000, 1'b1);
      to_frame_start(1'b1);
      frame_capture(1'b0, '0, 1'b1);
      check_frame("h0050", 7'b0000000, 7'b0000000,
                  7'b1101101, 7'b0111111, 4'b0000);

      do_load(16'h0000, 4'b0000, 1'b1);
      to_frame_start(1'b1);
      frame_capture(1'b0, '0, 1'b1);
      check_frame("h0000", 7'b0000000, 7'b0000000,
                  7'b0000000, 7'b0111111, 4'b0000);

      // Held valid: one accept now, the next only after the boundary.
      to_frame_start(1'b0);
      acc_seen = 0;
      cycle(1'b1, 16'h5678, 4'b0000, 1'b0);
      repeat (FRAME - 1) cycle(1'b1, 16'h9abc, 4'b0000, 1'b0);
      frame_capture(1'b1, 16'h9abc, 1'b0);
      check("hold_accepts", acc_seen, 2);
      check_frame("h5678", 7'b1101101, 7'b1111101,
                  7'b0000111, 7'b1111111, 4'b0000);
      frame_capture(1'b0, '0, 1'b0);
      check_frame("h9abc", 7'b1101111, 7'b1110111,
                  7'b1111100, 7'b0111001, 4'b0000);

      do_load(16'haf00, 4'b0100, 1'b0);
      to_frame_start(1'b0);
      frame_capture(1'b0, '0, 1'b0);
      check_frame("haf00", 7'b1110111, 7'b1110001,
                  7'b0111111, 7'b0111111, 4'b0100);

      // Random traffic with live lz toggling and one mid-run reset.
      lz = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         rd = 16'($urandom);
         nz = $urandom_range(0, 5);
         if (nz < 4) rd = rd & 16'((32'd1 << (4 * nz)) - 1);
         if ($urandom_range(0, 15) == 0) lz = ~lz;
         cycle(($urandom_range(0, 3) == 0), rd,
               4'($urandom), lz);
         if (i == 700) reset_pulse();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
